id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 64-bit RISC-V pipeline. Sits directly downstream of Register_File and captures read1/read2 together with decoded fields for the EX stage.
- Contains the load-use hazard detector. Produces the stall signal for the PC and IF/ID registers.
- Supports hold (downstream back-pressure) and flush (branch redirect).

Parameters:
- XLEN, 64, datapath width (PC, operands, immediate).
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_pc  in  XLEN  PC of the decoded instruction.
- id_rs1, id_rs2, id_rd  in  5 each  register specifiers.
- rf_read1, rf_read2  in  XLEN  Register_File combinational read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_ctrl  in  CTRL_W  control bundle.
- id_mem_read  in  1  instruction is a load.
- id_reg_write  in  1  instruction writes rd.
- wb_en  in  1  WB-stage register write enable (same signal as Register_File writeEn).
- wb_addr  in  5  WB destination.
- wb_data  in  XLEN  WB data.
- hold  in  1  freeze ID/EX (downstream stall).
- flush  in  1  squash the ID/EX contents (branch taken in EX).
- stall_out  out  1  freeze PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5  registered specifiers.
- ex_ctrl  out  CTRL_W  registered control bundle.
- ex_mem_read, ex_reg_write  out  1  registered.

Behaviour:
- Reset (async, any time):
  - All ex_* outputs go to 0. ex_valid=0, ex_mem_read=0, ex_reg_write=0.
  - stall_out is combinational and is 0 while ex_valid=0.
- Hazard detection (combinational):
  - hazard = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_rs1 == ex_rd) | (id_rs2 == ex_rd)).
  - The rs2 compare applies regardless of instruction type; a conservative stall is accepted.
- stall_out = ~flush & (hold | hazard).
- Per rising edge, priority order:
  - flush: load a bubble.
  - else hold: keep every register unchanged.
  - else hazard: load a bubble.
  - else: load from ID.
- Bubble definition:
  - ex_valid=0, ex_mem_read=0, ex_reg_write=0, ex_ctrl=0.
  - Data and specifier fields are don't-care; the implementation zeroes them.
- Load from ID:
  - ex_valid=id_valid.
  - ex_mem_read=id_mem_read & id_valid; ex_reg_write=id_reg_write & id_valid.
  - All other fields are copied.
- Latency: one cycle from ID inputs to ex_* outputs.
- Load-use timing: exactly one bubble per load-use pair. After the bubble, ex_mem_read=0, so hazard clears and the stalled instruction loads on the next edge.
- Back-to-back loads each dependent on the previous load: one bubble per pair.
- ex_rd=0 never triggers a hazard (x0).
- Flush and hazard in the same cycle: bubble, stall_out=0, so the upstream redirect proceeds.
- Hold and hazard in the same cycle: registers hold and stall_out=1. The hazard is re-evaluated when hold drops.

Optional Feature:
- Macro: ID_EX_WB_BYPASS_EN.
- With the macro defined:
  - The operand captured into ex_rs1_data is wb_data when wb_en & (wb_addr == id_rs1) & (id_rs1 != 0); otherwise it is rf_read1.
  - ex_rs2_data follows the same rule using id_rs2 and rf_read2.
  - This covers a same-edge write/read in Register_File.
- Without the macro: rf_read1/rf_read2 are captured unmodified. The register file must then provide write-first read behaviour.

Decomposition:
- Shared package riscv_pkg:
  - XLEN, REG_ADDR_W=5, CTRL_W.
  - Typedef id_ex_t: packed struct of all registered fields.
  - Constant ID_EX_BUBBLE of type id_ex_t.
- Sub-module hazard_unit (pure combinational):
  - Inputs: ex_valid, ex_mem_read, ex_rd, id_valid, id_rs1, id_rs2, hold, flush.
  - Output: stall_out and an internal bubble select.
  - Reused later for the forwarding unit.

Test Plan:
- Reset then pass-through: assert rst mid-cycle → all ex_* = 0 immediately. Then id_valid=1, id_pc=0x100, rf_read1=0x1234567890ABCDEF → next edge ex_pc=0x100, ex_rs1_data=0x1234567890ABCDEF, ex_valid=1.
- Load-use stall: load with rd=5 enters EX, then the next ID has rs1=5 → stall_out=1 for one cycle, ex_valid=0 (bubble). The following edge loads the dependent instruction and stall_out=0.
- x0 immunity: load with rd=0 in EX, ID rs1=0 → stall_out=0, no bubble.
- Flush priority: flush=1 together with hazard=1 and hold=1 → stall_out=0, next edge ex_valid=0, ex_reg_write=0.
- Hold: hold=1 for 3 cycles with changing ID inputs → ex_* frozen at their prior values and stall_out=1 throughout.
- Bypass (with ID_EX_WB_BYPASS_EN): wb_en=1, wb_addr=2, wb_data=0xFEDCBA0987654321, id_rs2=2, rf_read2=0 → ex_rs2_data=0xFEDCBA0987654321. With wb_addr=0 the value 0 is captured.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline types: datapath widths, the ID/EX register payload and its bubble value.
package riscv_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned CTRL_W     = 8;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [CTRL_W-1:0]     ctrl;
    logic                  mem_read;
    logic                  reg_write;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

  // Pick the WB result over the register-file read when WB writes the same non-x0 register this edge.
  function automatic logic [XLEN-1:0] wb_bypass(
    input logic                  wb_en,
    input logic [REG_ADDR_W-1:0] wb_addr,
    input logic [XLEN-1:0]       wb_data,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [XLEN-1:0]       rf_data
  );
    return (wb_en && (wb_addr == rs) && (rs != REG_ADDR_W'(0))) ? wb_data : rf_data;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side outputs of the ID/EX stage; slave is the stage, master drives it.
interface id_ex_stage_if;

  logic                                 id_valid;
  logic [riscv_pkg::XLEN-1:0]           id_pc;
  logic [riscv_pkg::REG_ADDR_W-1:0]     id_rs1;
  logic [riscv_pkg::REG_ADDR_W-1:0]     id_rs2;
  logic [riscv_pkg::REG_ADDR_W-1:0]     id_rd;
  logic [riscv_pkg::XLEN-1:0]           rf_read1;
  logic [riscv_pkg::XLEN-1:0]           rf_read2;
  logic [riscv_pkg::XLEN-1:0]           id_imm;
  logic [riscv_pkg::CTRL_W-1:0]         id_ctrl;
  logic                                 id_mem_read;
  logic                                 id_reg_write;
  logic                                 wb_en;
  logic [riscv_pkg::REG_ADDR_W-1:0]     wb_addr;
  logic [riscv_pkg::XLEN-1:0]           wb_data;
  logic                                 hold;
  logic                                 flush;

  logic                                 stall_out;
  logic                                 ex_valid;
  logic [riscv_pkg::XLEN-1:0]           ex_pc;
  logic [riscv_pkg::XLEN-1:0]           ex_rs1_data;
  logic [riscv_pkg::XLEN-1:0]           ex_rs2_data;
  logic [riscv_pkg::XLEN-1:0]           ex_imm;
  logic [riscv_pkg::REG_ADDR_W-1:0]     ex_rs1;
  logic [riscv_pkg::REG_ADDR_W-1:0]     ex_rs2;
  logic [riscv_pkg::REG_ADDR_W-1:0]     ex_rd;
  logic [riscv_pkg::CTRL_W-1:0]         ex_ctrl;
  logic                                 ex_mem_read;
  logic                                 ex_reg_write;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, rf_read1, rf_read2, id_imm, id_ctrl,
           id_mem_read, id_reg_write, wb_en, wb_addr, wb_data, hold, flush,
    input  stall_out, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_ctrl, ex_mem_read, ex_reg_write
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, rf_read1, rf_read2, id_imm, id_ctrl,
           id_mem_read, id_reg_write, wb_en, wb_addr, wb_data, hold, flush,
    output stall_out, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_ctrl, ex_mem_read, ex_reg_write
  );

endinterface

// File: rtl/id_ex_stage_hazard.sv
// Load-use hazard detector and ID/EX update arbitration (flush > hold > hazard > load); purely combinational.
module hazard_unit
  import riscv_pkg::*;
(
  input  logic                  i_ex_valid,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_hold,
  input  logic                  i_flush,
  output logic                  o_stall_c,
  output logic                  o_bubble_c,
  output logic                  o_load_en_c
);

  logic w_hazard;

  // rs2 is compared even for formats without rs2; the occasional extra stall is harmless.
  assign w_hazard = i_ex_valid && i_ex_mem_read && (i_ex_rd != REG_ADDR_W'(0)) && i_id_valid &&
                    ((i_id_rs1 == i_ex_rd) || (i_id_rs2 == i_ex_rd));

  assign o_stall_c   = !i_flush && (i_hold || w_hazard);
  assign o_load_en_c = i_flush || !i_hold;
  assign o_bubble_c  = i_flush || w_hazard;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, hold and flush.
// Define ID_EX_WB_BYPASS_EN to capture WB write data over same-edge register-file reads.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  id_ex_t          r_ex;
  id_ex_t          w_load;
  logic            w_stall;
  logic            w_bubble;
  logic            w_load_en;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;

  hazard_unit u_hazard (
    .i_ex_valid    (r_ex.valid),
    .i_ex_mem_read (r_ex.mem_read),
    .i_ex_rd       (r_ex.rd),
    .i_id_valid    (bus.id_valid),
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_hold        (bus.hold),
    .i_flush       (bus.flush),
    .o_stall_c     (w_stall),
    .o_bubble_c    (w_bubble),
    .o_load_en_c   (w_load_en)
  );

`ifdef ID_EX_WB_BYPASS_EN
  assign w_op1 = wb_bypass(bus.wb_en, bus.wb_addr, bus.wb_data, bus.id_rs1, bus.rf_read1);
  assign w_op2 = wb_bypass(bus.wb_en, bus.wb_addr, bus.wb_data, bus.id_rs2, bus.rf_read2);
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{bus.wb_en, bus.wb_addr, bus.wb_data};
  assign w_op1       = bus.rf_read1;
  assign w_op2       = bus.rf_read2;
`endif

  // Side-effect bits are qualified by id_valid so an empty decode slot never acts in EX.
  always_comb begin
    w_load           = ID_EX_BUBBLE;
    w_load.valid     = bus.id_valid;
    w_load.pc        = bus.id_pc;
    w_load.rs1_data  = w_op1;
    w_load.rs2_data  = w_op2;
    w_load.imm       = bus.id_imm;
    w_load.rs1       = bus.id_rs1;
    w_load.rs2       = bus.id_rs2;
    w_load.rd        = bus.id_rd;
    w_load.ctrl      = bus.id_ctrl;
    w_load.mem_read  = bus.id_mem_read && bus.id_valid;
    w_load.reg_write = bus.id_reg_write && bus.id_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex <= ID_EX_BUBBLE;
    end else if (w_load_en) begin
      r_ex <= w_bubble ? ID_EX_BUBBLE : w_load;
    end
  end

  assign bus.stall_out    = w_stall;
  assign bus.ex_valid     = r_ex.valid;
  assign bus.ex_pc        = r_ex.pc;
  assign bus.ex_rs1_data  = r_ex.rs1_data;
  assign bus.ex_rs2_data  = r_ex.rs2_data;
  assign bus.ex_imm       = r_ex.imm;
  assign bus.ex_rs1       = r_ex.rs1;
  assign bus.ex_rs2       = r_ex.rs2;
  assign bus.ex_rd        = r_ex.rd;
  assign bus.ex_ctrl      = r_ex.ctrl;
  assign bus.ex_mem_read  = r_ex.mem_read;
  assign bus.ex_reg_write = r_ex.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed reset/pass-through/bypass sequences plus a table-driven pipeline run.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage_if u_if ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        mr, rw, hold, flush;
    logic        e_stall, e_valid;
    logic [63:0] e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_mr, e_rw;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [63:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  ctrl;
    logic        mr, rw;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic logic [63:0] f_d1(input logic [63:0] pc);
    return pc ^ 64'hA5A5_0000_0000_5A5A;
  endfunction
  function automatic logic [63:0] f_d2(input logic [63:0] pc);
    return ~pc;
  endfunction
  function automatic logic [63:0] f_imm(input logic [63:0] pc);
    return pc + 64'h1000;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                          input logic rw);
    u_if.id_valid     = v;
    u_if.id_pc        = pc;
    u_if.id_rs1       = rs1;
    u_if.id_rs2       = rs2;
    u_if.id_rd        = rd;
    u_if.rf_read1     = f_d1(pc);
    u_if.rf_read2     = f_d2(pc);
    u_if.id_imm       = f_imm(pc);
    u_if.id_ctrl      = pc[7:0];
    u_if.id_mem_read  = mr;
    u_if.id_reg_write = rw;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ex_valid"},     64'(u_if.ex_valid), 64'h0);
    chk({tag, " ex_pc"},        u_if.ex_pc, 64'h0);
    chk({tag, " ex_rs1_data"},  u_if.ex_rs1_data, 64'h0);
    chk({tag, " ex_mem_read"},  64'(u_if.ex_mem_read), 64'h0);
    chk({tag, " ex_reg_write"}, 64'(u_if.ex_reg_write), 64'h0);
    chk({tag, " ex_ctrl"},      64'(u_if.ex_ctrl), 64'h0);
    chk({tag, " stall_out"},    64'(u_if.stall_out), 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    exp_t e;
    exp_t a;
    rst = 1'b1;
    drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    u_if.wb_en   = 1'b0;
    u_if.wb_addr = 5'd0;
    u_if.wb_data = 64'h0;
    u_if.hold    = 1'b0;
    u_if.flush   = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // Load enters EX, then reset is asserted mid-cycle with a dependent instruction in ID.
    drive_id(1'b1, 64'h200, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
    @(posedge clk);
    #1 chk("pre-rst ex_valid", 64'(u_if.ex_valid), 64'h1);
    drive_id(1'b1, 64'h204, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1);
    #1 chk("pre-rst stall", 64'(u_if.stall_out), 64'h1);
    #1 rst = 1'b1;
    #1 chk_zero("async rst");
    @(negedge clk);
    rst = 1'b0;

    // Pass-through with a fixed operand pattern.
    drive_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    u_if.rf_read1 = 64'h1234_5678_90AB_CDEF;
    @(posedge clk);
    #1;
    chk("pass ex_valid",    64'(u_if.ex_valid), 64'h1);
    chk("pass ex_pc",       u_if.ex_pc, 64'h100);
    chk("pass ex_rs1_data", u_if.ex_rs1_data, 64'h1234_5678_90AB_CDEF);

    do_reset();

    //            v  pc      rs1 rs2 rd  mr rw h  f   st ev epc     ers1 ers2 erd emr erw
    vecs.push_back(vec_t'{1, 'h100, 1,  2,  3,  0, 1, 0, 0,  0, 1, 'h100, 1,  2,  3,  0, 1});
    vecs.push_back(vec_t'{1, 'h104, 1,  2,  5,  1, 1, 0, 0,  0, 1, 'h104, 1,  2,  5,  1, 1});
    vecs.push_back(vec_t'{1, 'h108, 5,  6,  7,  0, 1, 0, 0,  1, 0, 'h0,   0,  0,  0,  0, 0});
    vecs.push_back(vec_t'{1, 'h108, 5,  6,  7,  0, 1, 0, 0,  0, 1, 'h108, 5,  6,  7,  0, 1});
    vecs.push_back(vec_t'{1, 'h10C, 0,  0,  0,  1, 1, 0, 0,  0, 1, 'h10C, 0,  0,  0,  1, 1});
    vecs.push_back(vec_t'{1, 'h110, 0,  0,  8,  0, 1, 0, 0,  0, 1, 'h110, 0,  0,  8,  0, 1});
    vecs.push_back(vec_t'{1, 'h114, 8,  9,  10, 1, 1, 0, 0,  0, 1, 'h114, 8,  9,  10, 1, 1});
    vecs.push_back(vec_t'{1, 'h118, 3,  10, 11, 1, 1, 0, 0,  1, 0, 'h0,   0,  0,  0,  0, 0});
    vecs.push_back(vec_t'{1, 'h118, 3,  10, 11, 1, 1, 0, 0,  0, 1, 'h118, 3,  10, 11, 1, 1});
    vecs.push_back(vec_t'{1, 'h11C, 11, 0,  12, 0, 1, 0, 0,  1, 0, 'h0,   0,  0,  0,  0, 0});
    vecs.push_back(vec_t'{1, 'h11C, 11, 0,  12, 0, 1, 0, 0,  0, 1, 'h11C, 11, 0,  12, 0, 1});
    vecs.push_back(vec_t'{1, 'h120, 1,  1,  13, 1, 1, 0, 0,  0, 1, 'h120, 1,  1,  13, 1, 1});
    vecs.push_back(vec_t'{1, 'h124, 13, 0,  14, 1, 1, 1, 0,  1, 1, 'h120, 1,  1,  13, 1, 1});
    vecs.push_back(vec_t'{1, 'h128, 13, 2,  20, 0, 0, 1, 0,  1, 1, 'h120, 1,  1,  13, 1, 1});
    vecs.push_back(vec_t'{1, 'h12C, 2,  13, 21, 1, 0, 1, 0,  1, 1, 'h120, 1,  1,  13, 1, 1});
    vecs.push_back(vec_t'{1, 'h124, 13, 0,  14, 1, 1, 0, 0,  1, 0, 'h0,   0,  0,  0,  0, 0});
    vecs.push_back(vec_t'{1, 'h124, 13, 0,  14, 1, 1, 0, 0,  0, 1, 'h124, 13, 0,  14, 1, 1});
    vecs.push_back(vec_t'{1, 'h130, 14, 0,  15, 0, 1, 1, 1,  0, 0, 'h0,   0,  0,  0,  0, 0});
    vecs.push_back(vec_t'{0, 'h134, 0,  0,  15, 1, 1, 0, 0,  0, 0, 'h134, 0,  0,  15, 0, 0});
    vecs.push_back(vec_t'{1, 'h138, 15, 0,  16, 0, 1, 0, 0,  0, 1, 'h138, 15, 0,  16, 0, 1});
    vecs.push_back(vec_t'{1, 'h13C, 0,  0,  17, 0, 1, 0, 1,  0, 0, 'h0,   0,  0,  0,  0, 0});
    vecs.push_back(vec_t'{1, 'h140, 0,  0,  1,  0, 1, 0, 0,  0, 1, 'h140, 0,  0,  1,  0, 1});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive_id(vecs[i].v, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr, vecs[i].rw);
      u_if.hold  = vecs[i].hold;
      u_if.flush = vecs[i].flush;
      #1 chk($sformatf("v%0d stall_out", i), 64'(u_if.stall_out), 64'(vecs[i].e_stall));
      e.valid = vecs[i].e_valid;
      e.pc    = vecs[i].e_pc;
      e.d1    = (vecs[i].e_pc == 64'h0) ? 64'h0 : f_d1(vecs[i].e_pc);
      e.d2    = (vecs[i].e_pc == 64'h0) ? 64'h0 : f_d2(vecs[i].e_pc);
      e.imm   = (vecs[i].e_pc == 64'h0) ? 64'h0 : f_imm(vecs[i].e_pc);
      e.rs1   = vecs[i].e_rs1;
      e.rs2   = vecs[i].e_rs2;
      e.rd    = vecs[i].e_rd;
      e.ctrl  = vecs[i].e_pc[7:0];
      e.mr    = vecs[i].e_mr;
      e.rw    = vecs[i].e_rw;
      sb.push_back(e);
      @(posedge clk);
      #1;
      a = sb.pop_front();
      chk($sformatf("v%0d ex_valid", i),     64'(u_if.ex_valid),     64'(a.valid));
      chk($sformatf("v%0d ex_pc", i),        u_if.ex_pc,             a.pc);
      chk($sformatf("v%0d ex_rs1_data", i),  u_if.ex_rs1_data,       a.d1);
      chk($sformatf("v%0d ex_rs2_data", i),  u_if.ex_rs2_data,       a.d2);
      chk($sformatf("v%0d ex_imm", i),       u_if.ex_imm,            a.imm);
      chk($sformatf("v%0d ex_rs1", i),       64'(u_if.ex_rs1),       64'(a.rs1));
      chk($sformatf("v%0d ex_rs2", i),       64'(u_if.ex_rs2),       64'(a.rs2));
      chk($sformatf("v%0d ex_rd", i),        64'(u_if.ex_rd),        64'(a.rd));
      chk($sformatf("v%0d ex_ctrl", i),      64'(u_if.ex_ctrl),      64'(a.ctrl));
      chk($sformatf("v%0d ex_mem_read", i),  64'(u_if.ex_mem_read),  64'(a.mr));
      chk($sformatf("v%0d ex_reg_write", i), 64'(u_if.ex_reg_write), 64'(a.rw));
    end
    u_if.hold  = 1'b0;
    u_if.flush = 1'b0;

    // WB write to the register being read this edge.
    @(negedge clk);
    drive_id(1'b1, 64'h300, 5'd2, 5'd2, 5'd4, 1'b0, 1'b1);
    u_if.rf_read1 = 64'h77;
    u_if.rf_read2 = 64'h0;
    u_if.wb_en    = 1'b1;
    u_if.wb_addr  = 5'd2;
    u_if.wb_data  = 64'hFEDC_BA09_8765_4321;
    @(posedge clk);
    #1;
`ifdef ID_EX_WB_BYPASS_EN
    chk("byp rs1", u_if.ex_rs1_data, 64'hFEDC_BA09_8765_4321);
    chk("byp rs2", u_if.ex_rs2_data, 64'hFEDC_BA09_8765_4321);
`else
    chk("byp rs1", u_if.ex_rs1_data, 64'h77);
    chk("byp rs2", u_if.ex_rs2_data, 64'h0);
`endif

    // WB to x0 is never forwarded.
    @(negedge clk);
    drive_id(1'b1, 64'h304, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
    u_if.rf_read1 = 64'h77;
    u_if.rf_read2 = 64'h0;
    u_if.wb_addr  = 5'd0;
    @(posedge clk);
    #1;
    chk("byp x0 rs1", u_if.ex_rs1_data, 64'h77);
    chk("byp x0 rs2", u_if.ex_rs2_data, 64'h0);

    // WB disabled: register-file data is captured.
    @(negedge clk);
    drive_id(1'b1, 64'h308, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1);
    u_if.rf_read2 = 64'h99;
    u_if.wb_en    = 1'b0;
    u_if.wb_addr  = 5'd2;
    @(posedge clk);
    #1 chk("byp off rs2", u_if.ex_rs2_data, 64'h99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
